// File: rtl/tpm_cmd_sequencer_if.sv
// rtl/tpm_cmd_sequencer_if.sv - I/O, back-end and response signals of the TPM command sequencer
interface tpm_cmd_sequencer_if #(
  parameter int NUM_SESSIONS = 3
);
  logic                    exec_start;
  logic [31:0]             command_code;
  logic [NUM_SESSIONS-1:0] session_valid;
  logic                    mm_start;
  logic                    mm_done;
  logic [31:0]             mm_rc;
  logic                    ee_start;
  logic                    ee_done;
  logic [31:0]             ee_rc;
  logic [31:0]             cmd_code_q;
  logic                    busy;
  logic                    response_ready;
  logic [31:0]             response_code;

  modport master (
    input  exec_start, command_code, session_valid, mm_done, mm_rc, ee_done, ee_rc,
    output mm_start, ee_start, cmd_code_q, busy, response_ready, response_code
  );

  modport slave (
    output exec_start, command_code, session_valid, mm_done, mm_rc, ee_done, ee_rc,
    input  mm_start, ee_start, cmd_code_q, busy, response_ready, response_code
  );
endinterface

// File: rtl/tpm_cmd_sequencer.sv
// rtl/tpm_cmd_sequencer.sv - validate/management/execution/respond sequencer with per-stage watchdog
// Optional statistics counters are enabled by defining TPM_SEQ_STATS_EN.
module tpm_cmd_sequencer #(
  parameter int NUM_SESSIONS   = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  tpm_cmd_sequencer_if.master    bus
`ifdef TPM_SEQ_STATS_EN
  ,
  output logic [15:0]            stat_cmds,
  output logic [15:0]            stat_errs,
  output logic [15:0]            stat_drops
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RC_AUTH_MISSING = 32'h0000_0125;
  localparam logic [31:0] RC_FAILURE      = 32'h0000_0101;

  typedef enum logic [2:0] {IDLE, CHECK, MGMT, EXEC, RESP} state_t;

  state_t                  state, state_next;
  logic [31:0]             rc_next;
  logic [NUM_SESSIONS-1:0] sess_q;
  logic [NUM_SESSIONS-1:0] sess_inc;
  logic                    mask_legal;
  logic [CW-1:0]           wd_cnt;
  logic                    wd_expired;
  logic                    mm_start_q, ee_start_q, busy_q, resp_ready_q;
  logic [31:0]             cmd_code_q, resp_code_q;

  // A mask is contiguous from bit 0 exactly when adding one clears every set bit.
  assign sess_inc   = sess_q + NUM_SESSIONS'(1);
  assign mask_legal = (sess_q & sess_inc) == '0;
  assign wd_expired = wd_cnt == WD_LAST;

  always_comb begin
    state_next = state;
    rc_next    = '0;
    case (state)
      IDLE: if (bus.exec_start) state_next = CHECK;
      CHECK: begin
        if (mask_legal) begin
          state_next = MGMT;
        end else begin
          rc_next    = RC_AUTH_MISSING;
          state_next = RESP;
        end
      end
      MGMT: begin
        // The start-pulse register doubles as the first-cycle flag; done is not trusted then.
        if (bus.mm_done && !mm_start_q) begin
          if (bus.mm_rc != '0) begin
            rc_next    = bus.mm_rc;
            state_next = RESP;
          end else begin
            state_next = EXEC;
          end
        end else if (wd_expired) begin
          rc_next    = RC_FAILURE;
          state_next = RESP;
        end
      end
      EXEC: begin
        if (bus.ee_done && !ee_start_q) begin
          rc_next    = bus.ee_rc;
          state_next = RESP;
        end else if (wd_expired) begin
          rc_next    = RC_FAILURE;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sess_q       <= '0;
      wd_cnt       <= '0;
      mm_start_q   <= 1'b0;
      ee_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      resp_ready_q <= 1'b0;
      cmd_code_q   <= '0;
      resp_code_q  <= '0;
    end else begin
      state        <= state_next;
      mm_start_q   <= (state_next == MGMT) && (state != MGMT);
      ee_start_q   <= (state_next == EXEC) && (state != EXEC);
      busy_q       <= state_next != IDLE;
      resp_ready_q <= state_next == RESP;
      if (state_next == RESP) resp_code_q <= rc_next;
      if (state == IDLE && bus.exec_start) begin
        cmd_code_q <= bus.command_code;
        sess_q     <= bus.session_valid;
      end
      if (state_next != state) wd_cnt <= '0;
      else if (state == MGMT || state == EXEC) wd_cnt <= wd_cnt + CW'(1);
    end
  end

  assign bus.mm_start       = mm_start_q;
  assign bus.ee_start       = ee_start_q;
  assign bus.busy           = busy_q;
  assign bus.response_ready = resp_ready_q;
  assign bus.cmd_code_q     = cmd_code_q;
  assign bus.response_code  = resp_code_q;

`ifdef TPM_SEQ_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_cmds  <= '0;
      stat_errs  <= '0;
      stat_drops <= '0;
    end else begin
      if (state_next == RESP && stat_cmds != 16'hFFFF) stat_cmds <= stat_cmds + 16'd1;
      if (state_next == RESP && rc_next != '0 && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      if (state != IDLE && bus.exec_start && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 16'd1;
    end
  end
`endif
endmodule
